// File: rtl/swc_gen.sv
// rtl/swc_gen.sv - instruction-driven stopwatch/countdown counter with prescaler and auto-reload
//
// Purpose:
//    Counter of width 8*BYTES controlled by 16-bit instructions from the
//    sequencer. Supports byte-indexed counter/reload loads, single steps,
//    continuous up/down counting that stops at zero, and a periodic
//    auto-reload mode that emits a one-cycle tick on each reload. Continuous
//    steps are paced by an 8-bit prescaler (one step every pre+1 idle cycles).
//
// Ports:
//    clock    in   1        system clock, rising edge
//    reset    in   1        asynchronous active-low reset
//    inst     in   16       instruction {code[3:0], sel[3:0], imm[7:0]}
//    inst_en  in   1        instruction valid
//    counter  out  8*BYTES  current counter value
//    ready    out  1        counter == 0
//    tick     out  1        one-cycle pulse on auto-reload
//    busy     out  1        continuous mode active
//    error    out  1        sticky error flag (cleared only by reset)

module swc_gen #(
   parameter int BYTES = 3
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [15:0]          inst,
   input  logic                 inst_en,
   output logic [8*BYTES-1:0]   counter,
   output logic                 ready,
   output logic                 tick,
   output logic                 busy,
   output logic                 error
);

   localparam int W = 8 * BYTES;
   localparam logic [4:0] BYTES_L = 5'(BYTES);

   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_LDC = 4'd1;
   localparam logic [3:0] OP_LDR = 4'd2;
   localparam logic [3:0] OP_LDP = 4'd3;
   localparam logic [3:0] OP_COU = 4'd4;
   localparam logic [3:0] OP_COD = 4'd5;
   localparam logic [3:0] OP_CCU = 4'd6;
   localparam logic [3:0] OP_CCD = 4'd7;
   localparam logic [3:0] OP_CCS = 4'd8;
   localparam logic [3:0] OP_CCR = 4'd9;
   localparam logic [3:0] OP_RLD = 4'd10;

   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_READY = 2'd1,
      ST_ERROR = 2'd2
   } st_e;

   typedef enum logic [1:0] {
      MODE_NONE   = 2'd0,
      MODE_UP     = 2'd1,
      MODE_DOWN   = 2'd2,
      MODE_RELOAD = 2'd3
   } mode_e;

   st_e            st_q,   st_d;
   mode_e          mode_q, mode_d;
   logic [W-1:0]   cnt_q,  cnt_d;
   logic [W-1:0]   rld_q,  rld_d;
   logic [7:0]     pre_q,  pre_d;
   logic [7:0]     pcnt_q, pcnt_d;
   logic           tick_q, tick_d;

   // Instruction fields
   logic [3:0]     code;
   logic [3:0]     sel;
   logic [7:0]     imm;
   logic           sel_ok;

   assign code   = inst[15:12];
   assign sel    = inst[11:8];
   assign imm    = inst[7:0];
   assign sel_ok = ({1'b0, sel} < BYTES_L);

   logic [W-1:0]   cnt_inc;
   logic [W-1:0]   cnt_dec;
   logic           cnt_zero;

   assign cnt_inc  = cnt_q + W'(1);
   assign cnt_dec  = cnt_q - W'(1);
   assign cnt_zero = (cnt_q == '0);

   // Result of a prescaled step opportunity in the current continuous mode.
   // UP/DOWN halt once the counter sits at zero; RELOAD refills from rld and
   // flags a tick instead.
   logic [W-1:0]   step_cnt;
   mode_e          step_mode;
   logic           step_tick;

   always_comb begin
      step_cnt  = cnt_q;
      step_mode = mode_q;
      step_tick = 1'b0;
      case (mode_q)
         MODE_UP: begin
            if (cnt_zero) step_mode = MODE_NONE;
            else          step_cnt  = cnt_inc;
         end
         MODE_DOWN: begin
            if (cnt_zero) step_mode = MODE_NONE;
            else          step_cnt  = cnt_dec;
         end
         MODE_RELOAD: begin
            if (cnt_zero) begin
               step_cnt  = rld_q;
               step_tick = 1'b1;
            end else begin
               step_cnt  = cnt_dec;
            end
         end
         default: ;
      endcase
   end

   // Next-state logic
   always_comb begin
      st_d   = st_q;
      mode_d = mode_q;
      cnt_d  = cnt_q;
      rld_d  = rld_q;
      pre_d  = pre_q;
      pcnt_d = pcnt_q;
      tick_d = 1'b0;

      case (st_q)
         ST_RESET: begin
            // Instructions presented in the release cycle are dropped.
            st_d = ST_READY;
         end

         ST_READY: begin
            if (inst_en) begin
               // An instruction always takes the slot of a continuous step.
               case (code)
                  OP_NOP: ;
                  OP_LDC: begin
                     if (sel_ok) begin
                        for (int b = 0; b < BYTES; b++) begin
                           if ({1'b0, sel} == 5'(b)) cnt_d[8*b +: 8] = imm;
                        end
                        mode_d = MODE_NONE;
                     end else begin
                        st_d   = ST_ERROR;
                        cnt_d  = '0;
                        mode_d = MODE_NONE;
                     end
                  end
                  OP_LDR: begin
                     if (sel_ok) begin
                        for (int b = 0; b < BYTES; b++) begin
                           if ({1'b0, sel} == 5'(b)) rld_d[8*b +: 8] = imm;
                        end
                     end else begin
                        st_d   = ST_ERROR;
                        cnt_d  = '0;
                        mode_d = MODE_NONE;
                     end
                  end
                  OP_LDP: begin
                     pre_d  = imm;
                     pcnt_d = 8'd0;
                  end
                  OP_COU: begin
                     cnt_d  = cnt_inc;
                     mode_d = MODE_NONE;
                  end
                  OP_COD: begin
                     cnt_d  = cnt_dec;
                     mode_d = MODE_NONE;
                  end
                  // Continuous modes start with an unconditional immediate
                  // step; the zero checks only apply to later steps.
                  OP_CCU: begin
                     cnt_d  = cnt_inc;
                     pcnt_d = 8'd0;
                     mode_d = MODE_UP;
                  end
                  OP_CCD: begin
                     cnt_d  = cnt_dec;
                     pcnt_d = 8'd0;
                     mode_d = MODE_DOWN;
                  end
                  OP_CCR: begin
                     cnt_d  = cnt_dec;
                     pcnt_d = 8'd0;
                     mode_d = MODE_RELOAD;
                  end
                  OP_CCS: begin
                     mode_d = MODE_NONE;
                  end
                  OP_RLD: begin
                     cnt_d  = rld_q;
                     mode_d = MODE_NONE;
                  end
                  default: begin
                     st_d   = ST_ERROR;
                     cnt_d  = '0;
                     mode_d = MODE_NONE;
                  end
               endcase
            end else if (mode_q != MODE_NONE) begin
               if (pcnt_q == pre_q) begin
                  pcnt_d = 8'd0;
                  cnt_d  = step_cnt;
                  mode_d = step_mode;
                  tick_d = step_tick;
               end else begin
                  pcnt_d = pcnt_q + 8'd1;
               end
            end
         end

         default: begin
            // Error is sticky: hold the counter cleared until reset.
            st_d   = ST_ERROR;
            cnt_d  = '0;
            mode_d = MODE_NONE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         st_q   <= ST_RESET;
         mode_q <= MODE_NONE;
         cnt_q  <= '0;
         rld_q  <= '0;
         pre_q  <= 8'd0;
         pcnt_q <= 8'd0;
         tick_q <= 1'b0;
      end else begin
         st_q   <= st_d;
         mode_q <= mode_d;
         cnt_q  <= cnt_d;
         rld_q  <= rld_d;
         pre_q  <= pre_d;
         pcnt_q <= pcnt_d;
         tick_q <= tick_d;
      end
   end

   assign counter = cnt_q;
   assign ready   = cnt_zero;
   assign tick    = tick_q;
   assign busy    = (mode_q != MODE_NONE) && (st_q == ST_READY);
   assign error   = (st_q == ST_ERROR);

endmodule

// File: tb/tb_swc_gen.sv
// tb/tb_swc_gen.sv - randomized self-checking bench for swc_gen against a behavioural model

module tb_swc_gen;

   localparam int BYTES = 3;
   localparam int W = 8 * BYTES;
   localparam longint MOD = 64'sd1 <<< W;

   logic           clock;
   logic           reset;
   logic [15:0]    inst;
   logic           inst_en;
   logic [W-1:0]   counter;
   logic           ready;
   logic           tick;
   logic           busy;
   logic           error;

   int n_checks;
   int n_errors;

   swc_gen #(.BYTES(BYTES)) dut (
      .clock   (clock),
      .reset   (reset),
      .inst    (inst),
      .inst_en (inst_en),
      .counter (counter),
      .ready   (ready),
      .tick    (tick),
      .busy    (busy),
      .error   (error)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Behavioural model: phase 0 = just out of reset, 1 = running, 2 = error.
   // Mode: 0 idle, 1 count up, 2 count down, 3 periodic reload.
   int     m_phase;
   int     m_mode;
   longint m_cnt;
   longint m_rld;
   int     m_pre;
   int     m_wait;
   bit     m_tick;

   function automatic void model_reset();
      m_phase = 0; m_mode = 0; m_cnt = 0; m_rld = 0;
      m_pre = 0; m_wait = 0; m_tick = 0;
   endfunction

   function automatic longint set_byte(longint v, int idx, int val);
      longint sh = 64'sd1 <<< (8 * idx);
      return v - ((v / sh) % 256) * sh + longint'(val) * sh;
   endfunction

   function automatic void model_fault();
      m_phase = 2; m_cnt = 0; m_mode = 0;
   endfunction

   function automatic void model_clock(bit en, logic [15:0] ins);
      int code = int'(ins[15:12]);
      int sel  = int'(ins[11:8]);
      int imm  = int'(ins[7:0]);
      m_tick = 0;
      if (m_phase == 0) begin
         m_phase = 1;
         return;
      end
      if (m_phase == 2) begin
         m_cnt = 0; m_mode = 0;
         return;
      end
      if (en) begin
         case (code)
            0: ;
            1: if (sel >= BYTES) model_fault();
               else begin m_cnt = set_byte(m_cnt, sel, imm); m_mode = 0; end
            2: if (sel >= BYTES) model_fault();
               else m_rld = set_byte(m_rld, sel, imm);
            3: begin m_pre = imm; m_wait = 0; end
            4: begin m_cnt = (m_cnt + 1) % MOD; m_mode = 0; end
            5: begin m_cnt = (m_cnt + MOD - 1) % MOD; m_mode = 0; end
            6: begin m_cnt = (m_cnt + 1) % MOD; m_wait = 0; m_mode = 1; end
            7: begin m_cnt = (m_cnt + MOD - 1) % MOD; m_wait = 0; m_mode = 2; end
            9: begin m_cnt = (m_cnt + MOD - 1) % MOD; m_wait = 0; m_mode = 3; end
            8: m_mode = 0;
            10: begin m_cnt = m_rld; m_mode = 0; end
            default: model_fault();
         endcase
      end else if (m_mode != 0) begin
         if (m_wait < m_pre) begin
            m_wait++;
         end else begin
            m_wait = 0;
            if (m_mode == 3) begin
               if (m_cnt == 0) begin m_cnt = m_rld; m_tick = 1; end
               else m_cnt = m_cnt - 1;
            end else if (m_cnt == 0) begin
               m_mode = 0;
            end else if (m_mode == 1) begin
               m_cnt = (m_cnt + 1) % MOD;
            end else begin
               m_cnt = m_cnt - 1;
            end
         end
      end
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      check("counter", 64'(counter), 64'(m_cnt));
      check("ready",   64'(ready),   64'(m_cnt == 0));
      check("tick",    64'(tick),    64'(m_tick));
      check("busy",    64'(busy),    64'(m_mode != 0 && m_phase == 1));
      check("error",   64'(error),   64'(m_phase == 2));
   endtask

   function automatic logic [15:0] mk(int code, int sel, int imm);
      return {4'(code), 4'(sel), 8'(imm)};
   endfunction

   // Drive one cycle: inputs set away from the edge, outputs sampled 1ns after it.
   task automatic cyc(input bit en, input logic [15:0] ins);
      inst_en = en;
      inst    = ins;
      @(posedge clock);
      model_clock(en, ins);
      #1;
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 16'h0000);
   endtask

   // Called 1ns after an edge: reset pulses low and releases between edges.
   task automatic do_reset();
      #2 reset = 1'b0;
      #1;
      model_reset();
      check_all();
      #2 reset = 1'b1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset    = 1'b0;
      inst     = 16'h0000;
      inst_en  = 1'b0;
      model_reset();
      #3;
      check_all();
      #3 reset = 1'b1;

      // Instruction in the release cycle is dropped.
      cyc(1'b1, mk(1, 0, 8'h10));
      check("release_ignored", 64'(counter), 64'h0);

      // Countdown from 5 with pre=0.
      cyc(1'b1, mk(1, 0, 8'h05));
      cyc(1'b1, mk(7, 0, 0));
      check("ccd_first", 64'(counter), 64'h4);
      idle(6);
      check("ccd_end_cnt", 64'(counter), 64'h0);
      check("ccd_end_busy", 64'(busy), 64'h0);

      // Count up through wrap-around.
      cyc(1'b1, mk(1, 2, 8'hFF));
      cyc(1'b1, mk(1, 1, 8'hFF));
      cyc(1'b1, mk(1, 0, 8'hFE));
      cyc(1'b1, mk(6, 0, 0));
      check("ccu_max", 64'(counter), 64'hFFFFFF);
      idle(1);
      check("ccu_wrap", 64'(counter), 64'h0);
      idle(3);
      check("ccu_stopped", 64'(busy), 64'h0);

      // Periodic reload: rld=2, pre=3.
      cyc(1'b1, mk(2, 0, 8'h02));
      cyc(1'b1, mk(3, 0, 8'h03));
      cyc(1'b1, mk(1, 0, 8'h01));
      cyc(1'b1, mk(9, 0, 0));
      check("ccr_imm", 64'(counter), 64'h0);
      idle(4);
      check("ccr_reload_cnt", 64'(counter), 64'h2);
      check("ccr_reload_tick", 64'(tick), 64'h1);
      idle(14);

      // Async reset between edges during CCR, then Reset->Ready cycle.
      do_reset();
      check("async_rst_cnt", 64'(counter), 64'h0);
      cyc(1'b1, mk(1, 0, 8'h22));
      check("post_rst_ignored", 64'(counter), 64'h0);

      // Illegal opcode during a countdown.
      cyc(1'b1, mk(1, 0, 8'h09));
      cyc(1'b1, mk(7, 0, 0));
      idle(1);
      cyc(1'b1, mk(11, 0, 0));
      check("bad_op_err", 64'(error), 64'h1);
      check("bad_op_cnt", 64'(counter), 64'h0);
      cyc(1'b1, mk(1, 0, 8'h33));
      cyc(1'b1, mk(4, 0, 0));
      check("err_sticky", 64'(counter), 64'h0);
      do_reset();
      idle(1);

      // Out-of-range byte select.
      cyc(1'b1, mk(1, 3, 8'h44));
      check("bad_sel_err", 64'(error), 64'h1);
      do_reset();
      idle(1);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         int r = int'($urandom_range(0, 99));
         int code;
         int sel;
         int imm;
         bit en;
         if (r < 2)       code = int'($urandom_range(11, 15));
         else             code = int'($urandom_range(0, 10));
         sel = ($urandom_range(0, 99) < 3) ? int'($urandom_range(3, 15))
                                           : int'($urandom_range(0, BYTES - 1));
         imm = (code == 3) ? int'($urandom_range(0, 3))
             : (($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 4))
                                            : int'($urandom_range(0, 255)));
         en  = ($urandom_range(0, 99) < 35);
         cyc(en, mk(code, sel, imm));
         if ($urandom_range(0, 299) == 0 || (m_phase == 2 && $urandom_range(0, 7) == 0))
            do_reset();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
